// File: rtl/mux_4x1.sv
// Registered one-of-N_IN bit selector: out <= in[s] on every rising clk edge.
// Define MUX_4X1_COMB_OUT_EN to drop the output register and make out = in[s] combinational.
module mux_4x1 #(
  parameter int N_IN  = 8,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IN-1:0]  in,
  input  logic [SEL_W-1:0] s,
  output logic             out
);

  // One-hot decode of the select, ANDed with the data bit it picks.
  logic [N_IN-1:0] hit;

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_dec
    assign hit[gi] = in[gi] & (s == SEL_W'(gi));
  end

  logic out_d;
  assign out_d = |hit;

`ifdef MUX_4X1_COMB_OUT_EN
  // clk and rst stay on the port list so both builds drop into the same socket.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;
  assign out = out_d;
`else
  logic out_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= 1'b0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;
`endif

endmodule

// File: tb/tb_mux_4x1.sv
// Self-checking bench for mux_4x1: directed sweeps with literal expectations plus
// randomized stimulus checked every negedge against a behavioural model.
module tb_mux_4x1;

  logic       clk;
  logic       rst;
  logic [7:0] in_v;
  logic [2:0] s_v;
  logic       out_w;

  int n_cmp = 0;
  int n_err = 0;

  mux_4x1 #(.N_IN(8), .SEL_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .in  (in_v),
    .s   (s_v),
    .out (out_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t in=%b s=%0d: got %b expected %b", name, $time, in_v, s_v, act, exp);
    end
  endtask

  // Behavioural model: remembers the (in, s) pair captured at the last edge
  // that was not under reset; any reset assertion forgets it.
  logic       chk_en = 1'b0;
  logic       last_valid = 1'b0;
  logic [7:0] last_in = '0;
  logic [2:0] last_s = '0;

  always @(posedge clk) begin
    if (rst) begin
      last_valid = 1'b0;
    end else begin
      last_valid = 1'b1;
      last_in    = in_v;
      last_s     = s_v;
    end
  end

  always @(posedge rst) last_valid = 1'b0;

  function automatic logic model_out();
`ifdef MUX_4X1_COMB_OUT_EN
    return ((in_v >> s_v) & 8'd1) != 8'd0;
`else
    if (rst || !last_valid) return 1'b0;
    return ((last_in >> last_s) & 8'd1) != 8'd0;
`endif
  endfunction

  always @(negedge clk) begin
    if (chk_en) check("cycle", out_w, model_out());
  end

  // Literal expectations for the three directed sweeps, s = 0..7.
  logic [7:0] pat [3];
  int         exp_seq [3][8];

  initial begin
    pat[0] = 8'b00010100;
    pat[1] = 8'b10010111;
    pat[2] = 8'b00101110;
    exp_seq[0] = '{0, 0, 1, 0, 1, 0, 0, 0};
    exp_seq[1] = '{1, 1, 1, 0, 1, 0, 0, 1};
    exp_seq[2] = '{0, 1, 1, 1, 0, 1, 0, 0};

    rst  = 1'b0;
    in_v = '0;
    s_v  = '0;

    // Reset behaviour
    #1;
    rst  = 1'b1;
    in_v = 8'hFF;
    s_v  = 3'd7;
    #1;
`ifdef MUX_4X1_COMB_OUT_EN
    check("comb_ignores_rst", out_w, 1'b1);
`else
    check("rst_async", out_w, 1'b0);
`endif
    chk_en = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
`ifdef MUX_4X1_COMB_OUT_EN
      check("comb_rst_hold", out_w, 1'b1);
`else
      check("rst_hold", out_w, 1'b0);
`endif
    end
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_release", out_w, 1'b1);
    $display("reset: in=%b s=%0d out=%b", in_v, s_v, out_w);

    // Directed sweeps
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 8; k++) begin
        in_v = pat[p];
        s_v  = 3'(k);
`ifdef MUX_4X1_COMB_OUT_EN
        #1;
        check("sweep", out_w, 1'(exp_seq[p][k]));
        $display("sweep%0d: in=%b s=%0d out=%b exp=%0d", p, in_v, k, out_w, exp_seq[p][k]);
        @(posedge clk); #1;
`else
        @(posedge clk); #1;
        check("sweep", out_w, 1'(exp_seq[p][k]));
        $display("sweep%0d: in=%b s=%0d out=%b exp=%0d", p, in_v, k, out_w, exp_seq[p][k]);
`endif
      end
    end

`ifndef MUX_4X1_COMB_OUT_EN
    // Asynchronous reset mid-stream, then release
    in_v = 8'b10010111;
    s_v  = 3'd7;
    @(posedge clk); #1;
    check("midrst_before", out_w, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("midrst_async", out_w, 1'b0);
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst_no_replay", out_w, 1'b0);
    @(posedge clk); #1;
    check("midrst_release", out_w, 1'b1);
    $display("midrst: in=%b s=%0d out=%b", in_v, s_v, out_w);
`endif

    // Randomized stimulus with occasional reset pulses spanning a negedge
    for (int i = 0; i < 300; i++) begin
      in_v = 8'($urandom);
      s_v  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) begin
        #1 rst = 1'b1;
        #5 rst = 1'b0;
        $display("rand%0d: in=%b s=%0d rst pulse", i, in_v, s_v);
      end else begin
        $display("rand%0d: in=%b s=%0d", i, in_v, s_v);
      end
      @(posedge clk); #1;
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux_4x1.md
Name: mux_4x1

Overview:
- Registered one-of-N bit selector: picks one bit of an N-bit input vector by a binary select and presents it on a single-bit output.
- Default configuration is N=8 with a 3-bit select; the historical "4x1" name is retained.
- Used as a leaf selection cell in datapath/control logic.
- Output is flopped on the system clock.

Parameters:
- N_IN, 8, number of selectable input bits; must be a power of two, minimum 2.
- SEL_W, 3, select width; must equal log2(N_IN).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all state immediately when asserted.
- in  input  N_IN  data vector; bit index k is selected when s==k.
- s  input  SEL_W  binary select; bit 0 is the LSB.
- out  output  1  selected bit, registered.

Behaviour:
- Reset: while rst=1, out=0 regardless of clk, in and s. Assertion takes effect without a clock edge. Release is synchronous-safe: the first rising edge with rst=0 loads a new value.
- Normal operation: on each rising clk edge with rst=0, out <= in[s].
- Latency: exactly 1 clock; out reflects the in/s values sampled at the previous rising edge.
- No enable and no handshake. The register updates every cycle.
- All select codes 0..N_IN-1 are legal; no out-of-range case exists since N_IN = 2^SEL_W.
- in and s may change together in the same cycle; the pair sampled at the edge determines out.
- Reset asserted mid-stream: out drops to 0 asynchronously. The pipeline value is discarded, not replayed after release.
- X/Z on s: no requirement. Bench must drive known values.
- Bit ordering: s=0 selects in[0] (LSB), s=N_IN-1 selects in[N_IN-1] (MSB).

Optional Feature:
- Macro: MUX_4X1_COMB_OUT_EN
- Defined: the output register is removed. out = in[s] combinationally with zero latency. rst and clk have no effect on out, but the ports remain present.
- Undefined (default): registered behaviour as specified above.

Test Plan:
- Reset: rst=1, in=8'hFF, s=3'd7 -> out=0 immediately and across edges. Release rst -> next edge out=1.
- Sweep in=8'b00010100, s=0..7 (one per cycle) -> out one cycle later: 0,0,1,0,1,0,0,0.
- Sweep in=8'b10010111, s=0..7 -> out: 1,1,1,0,1,0,0,1.
- Sweep in=8'b00101110, s=0..7 -> out: 0,1,1,1,0,1,0,0.
- Async reset mid-sweep: in=8'b10010111, s=7, out=1; assert rst between edges -> out=0 without waiting for clk. Deassert -> next edge out=1.
- With MUX_4X1_COMB_OUT_EN: repeat the in=8'b00010100 sweep -> out matches the expected sequence in the same cycle, with no one-cycle delay.
